// File: rtl/mcu_bridge_master.sv
// Initiator for the 4-bit address / 8-bit data MCU bridge bus.
// Optional sticky interrupt flag with int_clr: MCU_BRIDGE_INT_STICKY_EN.
module mcu_bridge_master #(
   parameter int unsigned SETUP_CYC  = 2,
   parameter int unsigned STROBE_CYC = 4,
   parameter int unsigned HOLD_CYC   = 2
) (
   input  logic       clk,
   input  logic       rst,
`ifdef MCU_BRIDGE_INT_STICKY_EN
   input  logic       int_clr,
`endif
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [3:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic [3:0] bus_addr,
   output logic       bus_rd,
   output logic       bus_wr,
   output logic [7:0] bus_data_out,
   output logic       bus_data_oe,
   input  logic [7:0] bus_data_in,
   input  logic       bus_int_in,
   output logic       int_level,
   output logic       int_pulse
);

   localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
   localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
   localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD
   } state_t;

   state_t     state;
   logic [7:0] cnt;
   logic       dir;
   logic       sync_q;

   // Bus cycle sequencer: setup, strobe and hold phases timed by cnt
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= 8'd0;
         dir          <= 1'b0;
         cmd_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= 8'd0;
         bus_addr     <= 4'd0;
         bus_rd       <= 1'b0;
         bus_wr       <= 1'b0;
         bus_data_out <= 8'd0;
         bus_data_oe  <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  bus_addr     <= cmd_addr;
                  bus_data_out <= cmd_wdata;
                  bus_data_oe  <= cmd_write;
                  dir          <= cmd_write;
                  cmd_ready    <= 1'b0;
                  cnt          <= SETUP_LD;
                  state        <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == 8'd0) begin
                  bus_wr <= dir;
                  bus_rd <= ~dir;
                  cnt    <= STROBE_LD;
                  state  <= STROBE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            STROBE: begin
               if (cnt == 8'd0) begin
                  // Responder holds data stable under rd, so no resync
                  if (!dir) rsp_rdata <= bus_data_in;
                  bus_wr <= 1'b0;
                  bus_rd <= 1'b0;
                  cnt    <= HOLD_LD;
                  state  <= HOLD;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            HOLD: begin
               if (cnt == 8'd0) begin
                  bus_data_oe <= 1'b0;
                  cmd_ready   <= 1'b1;
                  rsp_valid   <= ~dir;
                  state       <= IDLE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MCU_BRIDGE_INT_STICKY_EN
   logic sync_lvl;
   logic rise;

   assign rise = sync_q & ~sync_lvl;

   // Interrupt synchroniser with sticky flag; set wins over clear
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q    <= 1'b0;
         sync_lvl  <= 1'b0;
         int_level <= 1'b0;
         int_pulse <= 1'b0;
      end else begin
         sync_q    <= bus_int_in;
         sync_lvl  <= sync_q;
         int_pulse <= rise;
         int_level <= rise | (int_level & ~int_clr);
      end
   end
`else
   // Interrupt synchroniser; int_level is the second flop
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q    <= 1'b0;
         int_level <= 1'b0;
         int_pulse <= 1'b0;
      end else begin
         sync_q    <= bus_int_in;
         int_level <= sync_q;
         int_pulse <= sync_q & ~int_level;
      end
   end
`endif

endmodule

// File: tb/tb_mcu_bridge_master.sv
// Testbench for mcu_bridge_master: default, minimum and maximum timing.
// Read data is checked through a scoreboard queue.
module tb_mcu_bridge_master;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] cv  = 3'b000;
   logic       cmd_write = 1'b0;
   logic [3:0] cmd_addr  = 4'd0;
   logic [7:0] cmd_wdata = 8'd0;
   logic [7:0] resp_data = 8'd0;
   logic       bus_int_in = 1'b0;
`ifdef MCU_BRIDGE_INT_STICKY_EN
   logic       int_clr = 1'b0;
`endif

   logic       rdy [3];
   logic       rv  [3];
   logic       rd  [3];
   logic       wr  [3];
   logic       oe  [3];
   logic       il  [3];
   logic       ip  [3];
   logic [7:0] rdat[3];
   logic [7:0] dout[3];
   logic [3:0] ba  [3];
   logic [7:0] bus_data_in;

   int passed = 0;
   int total  = 0;
   logic [9:0] sbq[$];

   always #5 clk = ~clk;

   // Responder model: drives data only while some read strobe is high
   assign bus_data_in = (rd[0] | rd[1] | rd[2]) ? resp_data : 8'h00;

   mcu_bridge_master dut0 (
      .clk(clk), .rst(rst),
`ifdef MCU_BRIDGE_INT_STICKY_EN
      .int_clr(int_clr),
`endif
      .cmd_valid(cv[0]), .cmd_ready(rdy[0]), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rv[0]), .rsp_rdata(rdat[0]),
      .bus_addr(ba[0]), .bus_rd(rd[0]), .bus_wr(wr[0]),
      .bus_data_out(dout[0]), .bus_data_oe(oe[0]),
      .bus_data_in(bus_data_in), .bus_int_in(bus_int_in),
      .int_level(il[0]), .int_pulse(ip[0])
   );

   mcu_bridge_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut1 (
      .clk(clk), .rst(rst),
`ifdef MCU_BRIDGE_INT_STICKY_EN
      .int_clr(int_clr),
`endif
      .cmd_valid(cv[1]), .cmd_ready(rdy[1]), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rv[1]), .rsp_rdata(rdat[1]),
      .bus_addr(ba[1]), .bus_rd(rd[1]), .bus_wr(wr[1]),
      .bus_data_out(dout[1]), .bus_data_oe(oe[1]),
      .bus_data_in(bus_data_in), .bus_int_in(bus_int_in),
      .int_level(il[1]), .int_pulse(ip[1])
   );

   mcu_bridge_master #(.SETUP_CYC(255), .STROBE_CYC(255), .HOLD_CYC(255)) dut2 (
      .clk(clk), .rst(rst),
`ifdef MCU_BRIDGE_INT_STICKY_EN
      .int_clr(int_clr),
`endif
      .cmd_valid(cv[2]), .cmd_ready(rdy[2]), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rv[2]), .rsp_rdata(rdat[2]),
      .bus_addr(ba[2]), .bus_rd(rd[2]), .bus_wr(wr[2]),
      .bus_data_out(dout[2]), .bus_data_oe(oe[2]),
      .bus_data_in(bus_data_in), .bus_int_in(bus_int_in),
      .int_level(il[2]), .int_pulse(ip[2])
   );

   // Scoreboard: every rsp_valid pulse must match the oldest queued read
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            if (rv[i]) begin
               total++;
               if (sbq.size() == 0) begin
                  $display("FAIL rsp_unexpected inst=%0d got=%h required=none",
                           i, rdat[i]);
               end else begin
                  logic [9:0] exp;
                  exp = sbq.pop_front();
                  if ({2'(i), rdat[i]} !== exp)
                     $display("FAIL rsp_data inst/data got=%h required=%h",
                              {2'(i), rdat[i]}, exp);
                  else
                     passed++;
               end
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One command on instance i, checking every cycle up to ready again
   task automatic run_cmd(input int i, input int s, input int t, input int h,
                          input logic w, input logic [3:0] a,
                          input logic [7:0] d, input logic [7:0] rdv,
                          input bit inject);
      int n;
      logic [3:0] exp;
      logic [3:0] got;
      n = s + t + h;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      resp_data = rdv;
      cv[i]     = 1'b1;
      if (!w) sbq.push_back({2'(i), rdv});
      tick();
      cv[i] = 1'b0;
      total++;
      if ({ba[i], oe[i], rdy[i]} !== {a, w, 1'b0} || (w && dout[i] !== d))
         $display("FAIL accept inst=%0d got=%h/%h/%b/%b required=%h/%h/%b/0",
                  i, ba[i], dout[i], oe[i], rdy[i], a, d, w);
      else
         passed++;
      for (int k = 1; k <= n; k++) begin
         if (inject && k == s + 1) begin
            cmd_addr  = 4'h7;
            cmd_wdata = 8'h22;
            cmd_write = 1'b1;
            cv[i]     = 1'b1;
         end
         tick();
         exp = {w && k >= s && k < s + t, !w && k >= s && k < s + t,
                w && k < n, k == n};
         got = {wr[i], rd[i], oe[i], rdy[i]};
         total++;
         if (got !== exp || ba[i] !== a)
            $display("FAIL cycle inst=%0d k=%0d wr/rd/oe/rdy,addr got=%b,%h required=%b,%h",
                     i, k, got, ba[i], exp, a);
         else
            passed++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total++;
      if ({rdy[0], rv[0], rdat[0], ba[0], rd[0], wr[0], dout[0], oe[0],
           il[0], ip[0]} !== {1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00,
           1'b0, 1'b0, 1'b0})
         $display("FAIL reset_state got=%b/%b/%h/%h/%b/%b/%h/%b/%b/%b required=1/0/00/0/0/0/00/0/0/0",
                  rdy[0], rv[0], rdat[0], ba[0], rd[0], wr[0], dout[0], oe[0],
                  il[0], ip[0]);
      else
         passed++;
      total++;
      if ({rdy[1], rdy[2], oe[1], oe[2]} !== 4'b1100)
         $display("FAIL reset_others got=%b required=1100",
                  {rdy[1], rdy[2], oe[1], oe[2]});
      else
         passed++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_write();
      run_cmd(0, 2, 4, 2, 1'b1, 4'h3, 8'hA5, 8'h00, 1'b0);
      tick();
   endtask

   task automatic test_read();
      run_cmd(0, 2, 4, 2, 1'b0, 4'hC, 8'h00, 8'h5A, 1'b0);
      tick();
      run_cmd(0, 2, 4, 2, 1'b0, 4'h1, 8'hFF, 8'hC3, 1'b0);
      tick();
   endtask

   task automatic test_sweep();
      run_cmd(1, 1, 1, 1, 1'b1, 4'h9, 8'h3C, 8'h00, 1'b0);
      tick();
      run_cmd(1, 1, 1, 1, 1'b0, 4'h2, 8'h00, 8'h96, 1'b0);
      tick();
      run_cmd(2, 255, 255, 255, 1'b1, 4'hF, 8'h81, 8'h00, 1'b0);
      tick();
      run_cmd(2, 255, 255, 255, 1'b0, 4'h6, 8'h00, 8'h7E, 1'b0);
      tick();
   endtask

   task automatic test_back_to_back();
      run_cmd(0, 2, 4, 2, 1'b1, 4'h3, 8'h11, 8'h00, 1'b1);
      tick();
      cv[0] = 1'b0;
      total++;
      if ({ba[0], dout[0], oe[0], rdy[0]} !== {4'h7, 8'h22, 1'b1, 1'b0})
         $display("FAIL busy_accept got=%h/%h/%b/%b required=7/22/1/0",
                  ba[0], dout[0], oe[0], rdy[0]);
      else
         passed++;
      begin
         int wc;
         int n;
         wc = 0;
         n  = 0;
         while (!rdy[0] && n < 50) begin
            tick();
            wc += int'(wr[0]);
            n++;
         end
         total++;
         if (wc != 4 || !rdy[0])
            $display("FAIL busy_second_cmd wr_cycles got=%0d rdy=%b required=4 rdy=1",
                     wc, rdy[0]);
         else
            passed++;
      end
      tick();
   endtask

   task automatic test_reset_mid();
      for (int pass = 0; pass < 2; pass++) begin
         cmd_write = (pass == 0);
         cmd_addr  = 4'h5;
         cmd_wdata = 8'h66;
         resp_data = 8'h44;
         cv[0]     = 1'b1;
         tick();
         cv[0] = 1'b0;
         repeat (3) tick();
         total++;
         if ({wr[0], rd[0]} !== {pass == 0, pass == 1})
            $display("FAIL mid_strobe pass=%0d got=%b%b required=%b%b",
                     pass, wr[0], rd[0], pass == 0, pass == 1);
         else
            passed++;
         rst = 1'b1;
         tick();
         total++;
         if ({wr[0], rd[0], oe[0], rdy[0], rv[0]} !== 5'b00010)
            $display("FAIL reset_mid pass=%0d wr/rd/oe/rdy/rv got=%b required=00010",
                     pass, {wr[0], rd[0], oe[0], rdy[0], rv[0]});
         else
            passed++;
         rst = 1'b0;
         repeat (10) tick();
      end
      run_cmd(0, 2, 4, 2, 1'b0, 4'hA, 8'h00, 8'hE7, 1'b0);
      tick();
   endtask

   task automatic test_interrupt();
      #2;
      bus_int_in = 1'b1;
      tick();
      total++;
      if ({il[0], ip[0]} !== 2'b00)
         $display("FAIL int_edge1 got=%b required=00", {il[0], ip[0]});
      else
         passed++;
      tick();
      total++;
      if ({il[0], ip[0]} !== 2'b11)
         $display("FAIL int_edge2 got=%b required=11", {il[0], ip[0]});
      else
         passed++;
      tick();
      total++;
      if ({il[0], ip[0]} !== 2'b10)
         $display("FAIL int_pulse_width got=%b required=10", {il[0], ip[0]});
      else
         passed++;
      #2;
      bus_int_in = 1'b0;
      repeat (3) tick();
`ifdef MCU_BRIDGE_INT_STICKY_EN
      total++;
      if ({il[0], ip[0]} !== 2'b10)
         $display("FAIL int_sticky_hold got=%b required=10", {il[0], ip[0]});
      else
         passed++;
      int_clr = 1'b1;
      tick();
      int_clr = 1'b0;
      total++;
      if (il[0] !== 1'b0)
         $display("FAIL int_clear got=%b required=0", il[0]);
      else
         passed++;
      int_clr = 1'b1;
      #2;
      bus_int_in = 1'b1;
      tick();
      tick();
      total++;
      if ({il[0], ip[0]} !== 2'b11)
         $display("FAIL int_set_wins got=%b required=11", {il[0], ip[0]});
      else
         passed++;
      tick();
      int_clr = 1'b0;
      total++;
      if (il[0] !== 1'b0)
         $display("FAIL int_clear_held got=%b required=0", il[0]);
      else
         passed++;
      bus_int_in = 1'b0;
      repeat (3) tick();
`else
      total++;
      if ({il[0], ip[0]} !== 2'b00)
         $display("FAIL int_fall got=%b required=00", {il[0], ip[0]});
      else
         passed++;
`endif
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_sweep();
      test_back_to_back();
      test_reset_mid();
      test_interrupt();
      repeat (3) tick();
      total++;
      if (sbq.size() != 0)
         $display("FAIL rsp_missing got=%0d outstanding required=0", sbq.size());
      else
         passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mcu_bridge_master.md
Name: mcu_bridge_master

Overview:
- Initiator for the 4-bit-address / 8-bit-data parallel MCU bridge bus (addr, rd, wr, bidirectional data, int) that an ipm-style responder serves.
- Lets an FPGA-resident controller (picosoc peripheral or test harness) drive a remote ipm responder over PMOD/GPIO pins, replacing the external MCU.
- Converts single-beat host commands into timed rd/wr strobe cycles, captures read data and synchronises the responder's interrupt line.

Parameters:
- SETUP_CYC, 2, cycles address/data are valid before the strobe asserts (1..255)
- STROBE_CYC, 4, cycles rd/wr stays asserted (1..255)
- HOLD_CYC, 2, cycles address/data are held after the strobe deasserts (1..255)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  host command request
- cmd_ready  out  1  block idle and able to accept a command
- cmd_write  in  1  1 = bus write, 0 = bus read
- cmd_addr  in  4  bridge register address
- cmd_wdata  in  8  write data
- rsp_valid  out  1  one-cycle pulse, read data valid
- rsp_rdata  out  8  captured read data
- bus_addr  out  4  to responder address pins
- bus_rd  out  1  read strobe, active-high
- bus_wr  out  1  write strobe, active-high
- bus_data_out  out  8  data driven to the pad tristate
- bus_data_oe  out  1  pad output enable for bus_data_out
- bus_data_in  in  8  data from the pads
- bus_int_in  in  1  responder interrupt, asynchronous
- int_level  out  1  synchronised interrupt level
- int_pulse  out  1  one-cycle pulse on a synchronised rising edge of the interrupt

Behaviour:
- Reset values: cmd_ready=1, rsp_valid=0, rsp_rdata=0, bus_addr=0, bus_rd=0, bus_wr=0, bus_data_out=0, bus_data_oe=0, int_level=0, int_pulse=0, synchroniser flops=0, state=IDLE.
- All outputs are registered. cmd_ready = (state==IDLE).
- FSM states: IDLE, SETUP, STROBE, HOLD. An 8-bit down-counter is loaded on every state entry.
- IDLE: on cmd_valid&cmd_ready, latch addr, wdata and write into bus_addr, bus_data_out and a dir flag. bus_data_oe <= cmd_write. Go to SETUP with count SETUP_CYC-1.
- SETUP: strobes stay low. When the count reaches 0, go to STROBE. bus_wr<=dir and bus_rd<=~dir take effect on entry.
- STROBE: strobe held. In the final STROBE cycle of a read, rsp_rdata <= bus_data_in, sampled raw because the responder holds data stable under rd. Strobe deasserts on exit to HOLD.
- HOLD: bus_addr, bus_data_out and oe unchanged. On the final cycle return to IDLE, clear bus_data_oe, and pulse rsp_valid for one cycle if the command was a read.
- Timing: a command accepted at edge E0 gives strobe high for exactly STROBE_CYC cycles starting SETUP_CYC cycles after E0. cmd_ready returns SETUP_CYC+STROBE_CYC+HOLD_CYC cycles after E0.
- Idle bus: rd=wr=0, oe=0. bus_addr and bus_data_out keep their last values. rd and wr are never high simultaneously.
- cmd_valid while not ready is ignored. Inputs are not sampled and no queueing is done. Back-to-back commands are separated by at least one IDLE cycle.
- Reset mid-operation: on the next edge the strobes and oe drop to 0, the FSM goes to IDLE, and no rsp_valid is issued.
- Interrupt path: 2-flop synchroniser feeds int_level. int_pulse = int_level & ~prev_level. It operates independently of the FSM.

Optional Feature:
- Macro MCU_BRIDGE_INT_STICKY_EN.
- When defined:
  - Adds input int_clr (1 bit).
  - int_level becomes a sticky flag: set on a synchronised rising edge, cleared by int_clr.
  - A simultaneous set and clear leaves the flag set.
  - int_pulse is unchanged.
- When undefined: no int_clr port, and int_level is the plain synchronised level.

Test Plan:
- Write, defaults: cmd addr=0x3 wdata=0xA5 write=1 accepted at E0 -> bus_addr=0x3, data_out=0xA5, oe=1 from E0+1. bus_wr high during cycles E0+3..E0+6. bus_rd never high. oe=0 and cmd_ready=1 at E0+9.
- Read, defaults: cmd addr=0xC write=0, responder drives 0x5A while rd is high -> bus_rd high for 4 cycles, oe=0 throughout. rsp_valid single pulse with rsp_rdata=0x5A when the FSM returns to IDLE.
- Parameter sweep: SETUP=1, STROBE=1, HOLD=1 -> strobe exactly 1 cycle wide, ready again 3 cycles after accept. Check the 255/255/255 extreme.
- Busy rejection: assert cmd_valid with new addr=0x7 during STROBE -> bus_addr stays unchanged, no extra cycle issued. The command is accepted only once cmd_ready=1.
- Reset mid-write during STROBE -> next edge bus_wr=0, oe=0, cmd_ready=1, rsp_valid stays 0.
- Interrupt: raise bus_int_in asynchronously -> int_level rises 2 cycles later and int_pulse is a single cycle. With MCU_BRIDGE_INT_STICKY_EN, int_level remains 1 after the input drops until int_clr is pulsed.
